interface_ram_burst: RTL and testbench

- Single-clock successor of the cache-to-RAM interface: moves one cache line as a burst of RAM word transactions.
- Generalised over line width and word width.
- Adds features the previous interface lacked: per-word write mask (clean words skipped), critical-word-first wrapped reads, per-word ack timeout with error reporting.
- Sits between the cache controller and the word-wide RAM port; no FIFOs, no clock crossing.

---
 rtl/interface_ram_pkg.sv | 29 ++
 rtl/interface_ram_word_seq.sv | 77 +++++++
 rtl/interface_ram_burst.sv | 152 +++++++++++++++
 tb/tb_interface_ram_burst.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interface_ram_pkg.sv
// Shared types and helpers for the cache-line to RAM-word burst interface.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package interface_ram_pkg;

  // Burst controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Number of RAM words in one cache line
  function automatic int words_f(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // Word-index width; never narrower than one bit so single-word lines still work
  function automatic int idxw_f(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Bit offset of word idx inside a line
  function automatic int word_lsb(input int idx, input int word_w);
    return idx * word_w;
  endfunction

endpackage

// File: rtl/interface_ram_word_seq.sv
// Word-index sequencer: wrapped order from crit for reads, ascending dirty words for writes.
// Latency: idx valid the cycle after load; advances one word per adv pulse.
// Backpressure: holds idx until adv; last flags the final word of the burst.
module interface_ram_word_seq
  import interface_ram_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            rnw,
  input  logic [WORDS-1:0] mask,
  input  logic [IDXW-1:0] crit,
  input  logic            adv,
  output logic [IDXW-1:0] idx,
  output logic            last
);

  logic             rnw_q;
  logic [WORDS-1:0] mask_q;
  logic [IDXW-1:0]  crit_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  first_idx;
  logic [IDXW-1:0]  wrap_idx;
  logic [IDXW-1:0]  skip_idx;
  logic             skip_found;

  // Starting word: crit for reads, lowest dirty word for writes
  always_comb begin
    first_idx = crit;
    if (!rnw) begin
      first_idx = '0;
      for (int i = WORDS - 1; i >= 0; i--) begin
        if (mask[i]) first_idx = IDXW'(i);
      end
    end
  end

  // Next dirty word strictly above the current one (lowest such index wins)
  always_comb begin
    skip_idx   = '0;
    skip_found = 1'b0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(idx_q))) begin
        skip_idx   = IDXW'(i);
        skip_found = 1'b1;
      end
    end
  end

  // Modulo-WORDS increment so non-power-of-two lines wrap correctly
  assign wrap_idx = (idx_q == IDXW'(WORDS - 1)) ? '0 : idx_q + 1'b1;

  // A read ends when the next word would be crit again; a write when no dirty word remains
  assign last = rnw_q ? (wrap_idx == crit_q) : !skip_found;
  assign idx  = idx_q;

  // Capture the burst shape on accept, then step on each completed word
  always_ff @(posedge clk) begin
    if (rst) begin
      rnw_q  <= 1'b0;
      mask_q <= '0;
      crit_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      rnw_q  <= rnw;
      mask_q <= mask;
      crit_q <= crit;
      idx_q  <= first_idx;
    end else if (adv) begin
      idx_q  <= rnw_q ? wrap_idx : skip_idx;
    end
  end

endmodule

// File: rtl/interface_ram_burst.sv
// Moves one cache line to/from a word-wide RAM as a burst (masked writes, critical-word-first reads).
// Latency: accept at T, first RAM word at T+1, cache_ack at T+N+1 with zero-wait RAM; empty write at T+1.
// Backpressure: cache_ready only in IDLE; each RAM word held until ram_ack or TIMEOUT stalled cycles.
module interface_ram_burst
  import interface_ram_pkg::*;
#(
  parameter int ADDR_SIZE       = 13,
  parameter int CACHE_STR_WIDTH = 64,
  parameter int WORD_SIZE       = 16,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cache_avalid,
  input  logic                       cache_rnw,
  input  logic [ADDR_SIZE-1:0]       cache_addr,
  input  logic [CACHE_STR_WIDTH-1:0] cache_wdata,
  input  logic [words_f(CACHE_STR_WIDTH, WORD_SIZE)-1:0] cache_wmask,
  input  logic [idxw_f(words_f(CACHE_STR_WIDTH, WORD_SIZE))-1:0] cache_crit,
  output logic                       cache_ready,
  output logic [CACHE_STR_WIDTH-1:0] cache_rdata,
  output logic                       cache_ack,
  output logic                       cache_err,
  output logic [ADDR_SIZE-1:0]       ram_addr,
  output logic [WORD_SIZE-1:0]       ram_wdata,
  output logic                       ram_avalid,
  output logic                       ram_rnw,
  input  logic [WORD_SIZE-1:0]       ram_rdata,
  input  logic                       ram_ack
);

  localparam int WORDS = words_f(CACHE_STR_WIDTH, WORD_SIZE);
  localparam int IDXW  = idxw_f(WORDS);
  localparam int TCW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t                     state;
  state_t                     state_nxt;
  logic [ADDR_SIZE-IDXW-1:0]  base_q;
  logic                       rnw_q;
  logic [CACHE_STR_WIDTH-1:0] wdata_q;
  logic [CACHE_STR_WIDTH-1:0] rdata_q;
  logic [TCW-1:0]             tcnt;
  logic                       accept;
  logic                       word_ack;
  logic                       timed_out;
  logic [IDXW-1:0]            idx;
  logic                       last;
  logic                       unused_addr_low;

  // Line-offset address bits are deliberately dropped: bursts are always line aligned
  assign unused_addr_low = ^cache_addr[IDXW-1:0];

  assign accept    = (state == IDLE) && cache_avalid;
  assign word_ack  = (state == XFER) && ram_ack;
  // The final stalled cycle is the one where the counter already holds TIMEOUT-1
  assign timed_out = (TIMEOUT != 0) && (tcnt == TCW'(TLIM));
  assign cache_rdata = rdata_q;

  interface_ram_word_seq #(
    .WORDS (WORDS),
    .IDXW  (IDXW)
  ) u_word_seq (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .rnw  (cache_rnw),
    .mask (cache_wmask),
    .crit (cache_crit),
    .adv  (word_ack),
    .idx  (idx),
    .last (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; ram ack outside XFER falls through untouched
  always_comb begin
    state_nxt   = state;
    cache_ready = 1'b0;
    cache_ack   = 1'b0;
    cache_err   = 1'b0;
    ram_avalid  = 1'b0;
    ram_rnw     = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (state)
      IDLE: begin
        cache_ready = 1'b1;
        if (cache_avalid) begin
          state_nxt = (!cache_rnw && (cache_wmask == '0)) ? DONE : XFER;
        end
      end
      XFER: begin
        ram_avalid = 1'b1;
        ram_rnw    = rnw_q;
        ram_addr   = {base_q, idx};
        ram_wdata  = wdata_q[word_lsb(int'(idx), WORD_SIZE) +: WORD_SIZE];
        if (ram_ack) begin
          if (last) state_nxt = DONE;
        end else if (timed_out) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        cache_ack = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        cache_ack = 1'b1;
        cache_err = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; the cache side is free to change its inputs after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      base_q  <= cache_addr[ADDR_SIZE-1:IDXW];
      rnw_q   <= cache_rnw;
      wdata_q <= cache_wdata;
    end
  end

  // Read line assembly: only acked read words update, so a timed-out line keeps older words
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (word_ack && rnw_q) begin
      for (int i = 0; i < WORDS; i++) begin
        if (i == int'(idx)) rdata_q[word_lsb(i, WORD_SIZE) +: WORD_SIZE] <= ram_rdata;
      end
    end
  end

  // Per-word stall counter: zero outside XFER and on every ack
  always_ff @(posedge clk) begin
    if (rst || (state != XFER) || ram_ack) tcnt <= '0;
    else                                   tcnt <= tcnt + 1'b1;
  end

endmodule

// File: tb/tb_interface_ram_burst.sv
// Self-checking bench for interface_ram_burst with a behavioural RAM and line-level reference model.
// Latency: checks exact cache_ack cycle and the per-cycle RAM request stream.
// Backpressure: RAM ack delay is varied per request; one request hangs a word to force timeout.
module tb_interface_ram_burst;

  localparam int AW    = 13;
  localparam int LW    = 64;
  localparam int WW    = 16;
  localparam int WORDS = 4;
  localparam int TO    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cache_avalid;
  logic            cache_rnw;
  logic [AW-1:0]   cache_addr;
  logic [LW-1:0]   cache_wdata;
  logic [WORDS-1:0] cache_wmask;
  logic [1:0]      cache_crit;
  logic            cache_ready;
  logic [LW-1:0]   cache_rdata;
  logic            cache_ack;
  logic            cache_err;
  logic [AW-1:0]   ram_addr;
  logic [WW-1:0]   ram_wdata;
  logic            ram_avalid;
  logic            ram_rnw;
  logic [WW-1:0]   ram_rdata;
  logic            ram_ack;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic          rnw;
  } txn_t;

  logic [WW-1:0] mem     [0:(1<<AW)-1];
  logic [WW-1:0] ref_mem [0:(1<<AW)-1];
  logic [LW-1:0] ref_rdata;
  txn_t          log_q[$];
  txn_t          exp_q[$];
  int            cyc = 0;
  int            stall = 0;
  int            delay = 0;
  int            ack_seen = 0;
  logic          hang_en = 1'b0;
  logic [AW-1:0] hang_addr = '0;
  logic          spur_ack = 1'b0;
  int            checks = 0;
  int            failures = 0;

  interface_ram_burst #(
    .ADDR_SIZE       (AW),
    .CACHE_STR_WIDTH (LW),
    .WORD_SIZE       (WW),
    .TIMEOUT         (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cache_avalid (cache_avalid),
    .cache_rnw    (cache_rnw),
    .cache_addr   (cache_addr),
    .cache_wdata  (cache_wdata),
    .cache_wmask  (cache_wmask),
    .cache_crit   (cache_crit),
    .cache_ready  (cache_ready),
    .cache_rdata  (cache_rdata),
    .cache_ack    (cache_ack),
    .cache_err    (cache_err),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_avalid   (ram_avalid),
    .ram_rnw      (ram_rnw),
    .ram_rdata    (ram_rdata),
    .ram_ack      (ram_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] init_word(input int i);
    return WW'(i * 40503 + 12345);
  endfunction

  // RAM responder: acks after 'delay' stalled cycles, never acks the hang address
  assign ram_ack   = (ram_avalid && (stall >= delay) && !(hang_en && (ram_addr == hang_addr))) || spur_ack;
  assign ram_rdata = ram_avalid ? mem[ram_addr] : '0;

  // RAM storage, request log and ack counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
    end
    if (ram_avalid) begin
      log_q.push_back('{addr: ram_addr, wdata: ram_wdata, rnw: ram_rnw});
      if (ram_ack && !ram_rnw) mem[ram_addr] <= ram_wdata;
    end
    if (ram_avalid && !ram_ack) stall <= stall + 1;
    else                        stall <= 0;
    if (cache_ack) ack_seen <= ack_seen + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One line request; expectations come from the line-level model (word order, repeats, ack time)
  task automatic do_req(input logic rnw, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                        input logic [3:0] wm, input logic [1:0] crit, input int d,
                        input int hang_word, input bit extra);
    int            order[$];
    int            t, total, tmo, reps, w;
    logic [AW-1:0] base, a;
    logic          err_exp;
    logic [LW-1:0] exp_line;
    base     = addr & ~13'h3;
    err_exp  = 1'b0;
    exp_line = ref_rdata;
    total    = 0;
    if (rnw) begin
      for (int k = 0; k < WORDS; k++) order.push_back((int'(crit) + k) % WORDS);
    end else begin
      for (int i = 0; i < WORDS; i++) if (wm[i]) order.push_back(i);
    end
    exp_q.delete();
    for (int j = 0; j < order.size(); j++) begin
      w    = order[j];
      a    = base | AW'(w);
      reps = (w == hang_word) ? TO : d + 1;
      for (int r = 0; r < reps; r++) exp_q.push_back('{addr: a, wdata: wd[w*WW +: WW], rnw: rnw});
      total += reps;
      if (w == hang_word) begin
        err_exp = 1'b1;
        break;
      end
      if (rnw) exp_line[w*WW +: WW] = ref_mem[a];
      else     ref_mem[a] = wd[w*WW +: WW];
    end

    @(negedge clk);
    chk("idle_ready", cache_ready, 1);
    delay     = d;
    hang_en   = (hang_word >= 0);
    hang_addr = base | AW'(hang_word);
    log_q.delete();
    cache_avalid = 1'b1;
    cache_rnw    = rnw;
    cache_addr   = addr;
    cache_wdata  = wd;
    cache_wmask  = wm;
    cache_crit   = crit;
    t = cyc;
    @(negedge clk);
    chk("busy_ready", cache_ready, 0);
    if (extra) begin
      cache_addr  = ~addr;
      cache_rnw   = ~rnw;
      cache_wmask = '1;
    end else begin
      cache_avalid = 1'b0;
    end
    tmo = 0;
    while (!cache_ack && tmo < 200) begin
      @(negedge clk);
      cache_avalid = 1'b0;
      tmo++;
    end
    cache_avalid = 1'b0;
    chk("ack_wait_bound", (tmo < 200), 1);
    chk("ack_cycle", cyc, t + 1 + total);
    chk("ack_err", cache_err, err_exp);
    if (rnw) ref_rdata = exp_line;
    chk("rdata", cache_rdata, ref_rdata);
    chk("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("txn_addr", log_q[i].addr, exp_q[i].addr);
      chk("txn_rnw", log_q[i].rnw, exp_q[i].rnw);
      if (!exp_q[i].rnw) chk("txn_wdata", log_q[i].wdata, exp_q[i].wdata);
    end
    @(negedge clk);
    chk("ack_pulse", cache_ack, 0);
    chk("back_idle", cache_ready, 1);
    chk("rdata_hold", cache_rdata, ref_rdata);
    hang_en = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] rbase;
    logic [LW-1:0] rwd;
    int            t, a0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    ref_rdata    = '0;
    rst          = 1'b1;
    cache_avalid = 1'b0;
    cache_rnw    = 1'b0;
    cache_addr   = '0;
    cache_wdata  = '0;
    cache_wmask  = '0;
    cache_crit   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cache_ready, 1);
    chk("rst_ack", cache_ack, 0);
    chk("rst_err", cache_err, 0);
    chk("rst_avalid", ram_avalid, 0);
    chk("rst_raddr", ram_addr, 0);
    chk("rst_rdata", cache_rdata, 0);
    rst = 1'b0;

    // Stray ack with no RAM request outstanding must do nothing
    @(negedge clk);
    spur_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("spur_ack", cache_ack, 0);
    chk("spur_ready", cache_ready, 1);
    chk("spur_rdata", cache_rdata, 0);
    spur_ack = 1'b0;

    // Directed cases
    do_req(1'b1, 13'h0104, '0, 4'b0000, 2'd2, 0, -1, 1'b0);
    do_req(1'b0, 13'h0200, 64'hDDDD_CCCC_BBBB_AAAA, 4'b1010, 2'd0, 0, -1, 1'b1);
    do_req(1'b0, 13'h0208, 64'h1234_5678_9ABC_DEF0, 4'b0000, 2'd0, 0, -1, 1'b0);
    do_req(1'b1, 13'h0200, '0, 4'b0000, 2'd0, 0, -1, 1'b0);
    do_req(1'b1, 13'h0404, '0, 4'b0000, 2'd0, 1, 1, 1'b0);
    do_req(1'b1, 13'h0107, '0, 4'b0000, 2'd1, 3, -1, 1'b1);

    // Reset in the middle of a write, during the second word's stall
    rbase = 13'h0300;
    rwd   = {$urandom, $urandom};
    @(negedge clk);
    delay        = 2;
    cache_avalid = 1'b1;
    cache_rnw    = 1'b0;
    cache_addr   = rbase;
    cache_wdata  = rwd;
    cache_wmask  = 4'b1111;
    t = cyc;
    @(negedge clk);
    cache_avalid = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    chk("mid_addr", ram_addr, rbase | 13'h1);
    a0  = ack_seen;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_avalid", ram_avalid, 0);
    chk("mid_rst_ready", cache_ready, 1);
    chk("mid_rst_ack", cache_ack, 0);
    chk("mid_rst_rdata", cache_rdata, 0);
    rst = 1'b0;
    ref_mem[rbase] = rwd[WW-1:0];
    ref_rdata      = '0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_ack", ack_seen, a0);
    do_req(1'b1, rbase, '0, 4'b0000, 2'd3, 0, -1, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, 4'($urandom),
             2'($urandom), $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
